// File: rtl/cpu_defs_pkg.sv
// Shared constants for the P5 front end: reset/IM defaults, next-PC kinds,
// and the fetch-legality helper.
package cpu_defs;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // The offset is 33 bits wide so that addresses below base wrap into the upper half and fail.
  function automatic logic fetch_legal(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [32:0] limit_bytes);
    logic [32:0] off;
    off = {1'b0, pc} - {1'b0, base};
    return (pc[1:0] == 2'b00) && !off[32] && (off < limit_bytes);
  endfunction

endpackage

// File: rtl/npc_unit.sv
// Combinational redirect target computation and next-PC selection,
// using the D-stage instruction and PC.
module npc_unit
  import cpu_defs::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  always_comb begin
    seq_pc    = f_pc + 32'd4;
    br_target = d_pc + 32'd4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
    j_target  = {d_pc[31:28], d_imm26, 2'b00};
    npc       = seq_pc;
    case (npc_sel)
      NPC_BR:  npc = br_taken ? br_target : seq_pc;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = d_rs_val;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// F-stage PC register and IF/ID pipeline register for the P5 MIPS core.
// Redirects come from D and always keep their delay-slot instruction.
module fetch_ifid_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] d_rs_val,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        addr_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc8_q, d_pc8_d;
  logic        d_valid_q, d_valid_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] npc;
  logic        fetch_ok;

  npc_unit u_npc (
    .f_pc     (f_pc_q),
    .d_pc     (d_pc_q),
    .d_imm26  (d_instr_q[25:0]),
    .d_rs_val (d_rs_val),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .npc      (npc)
  );

  // A stall freezes everything, including the redirect; D re-presents it once stall drops.
  always_comb begin
    fetch_ok    = fetch_legal(f_pc_q, IM_BASE, IM_BYTES);
    f_pc_d      = f_pc_q;
    d_instr_d   = d_instr_q;
    d_pc_d      = d_pc_q;
    d_pc8_d     = d_pc8_q;
    d_valid_d   = d_valid_q;
    addr_err_d  = addr_err_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall) begin
      f_pc_d      = npc;
      d_instr_d   = fetch_ok ? im_rdata : NOP;
      d_pc_d      = f_pc_q;
      d_pc8_d     = f_pc_q + 32'd8;
      d_valid_d   = fetch_ok;
      addr_err_d  = addr_err_q | ~fetch_ok;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q      <= PC_RESET;
      d_instr_q   <= NOP;
      d_pc_q      <= 32'd0;
      d_pc8_q     <= 32'd8;
      d_valid_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      f_pc_q      <= f_pc_d;
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_pc8_q     <= d_pc8_d;
      d_valid_q   <= d_valid_d;
      addr_err_q  <= addr_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign im_addr   = f_pc_q;
  assign d_instr   = d_instr_q;
  assign d_pc      = d_pc_q;
  assign d_pc8     = d_pc8_q;
  assign d_valid   = d_valid_q;
  assign addr_err  = addr_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Pipeline front end for the P5 five-stage MIPS core: F-stage PC register, next-PC selection, and the IF/ID pipeline register that feeds the D-stage instruction decoder.
- Redirects are resolved in D and have one architectural delay slot, so the instruction already fetched always completes and is never flushed.
- Instruction memory sits outside this block as a combinational ROM addressed by im_addr.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_WORDS, 4096, instruction memory depth in words. Legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
stall  in  1  from the hazard unit; freezes the PC and IF/ID.
npc_sel  in  2  D-stage next-PC kind: 00 sequential, 01 branch (beq/blt), 10 j/jal, 11 jr.
br_taken  in  1  D-stage branch comparison result; meaningful only when npc_sel=01.
d_rs_val  in  32  forwarded rs value for jr.
im_addr  out  32  fetch address, equal to F_PC.
im_rdata  in  32  instruction word at im_addr, combinational.
d_instr  out  32  IF/ID instruction, drives the decoder's Instr input.
d_pc  out  32  PC of d_instr.
d_pc8  out  32  d_pc+8, the jal link value.
d_valid  out  1  d_instr came from a real, legal fetch.
addr_err  out  1  sticky flag: an illegal or misaligned fetch has occurred.
fetch_cnt  out  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (async, immediate on assertion): F_PC=PC_RESET; d_instr=0 (nop); d_pc=0; d_pc8=8; d_valid=0; addr_err=0; fetch_cnt=0.
- Reset asserted mid-operation discards everything in flight. The first fetch after deassertion is PC_RESET.
- im_addr = F_PC, combinational.
- Target computation, from D-stage values, all arithmetic mod 2^32:
  - branch target = d_pc + 4 + (sign-extended d_instr[15:0] << 2)
  - j/jal target = {d_pc[31:28], d_instr[25:0], 2'b00}
  - jr target = d_rs_val
- NPC selection:
  - npc_sel=01 and br_taken=1: branch target.
  - npc_sel=10: j/jal target.
  - npc_sel=11: jr target.
  - Otherwise (00, or 01 with br_taken=0): F_PC+4, wrapping from 32'hFFFF_FFFC to 0.
- Per rising edge with stall=0:
  - F_PC <= NPC; d_instr <= fetched word; d_pc <= F_PC; d_pc8 <= F_PC+8; d_valid <= 1; fetch_cnt += 1 (wraps at 2^32).
  - The delay-slot instruction is the one fetched in the same cycle the redirect is seen. It enters IF/ID normally.
- Per rising edge with stall=1:
  - F_PC and all IF/ID outputs hold; fetch_cnt holds.
  - npc_sel and br_taken are ignored, because the stalled D instruction re-presents its redirect on the cycle stall drops. This avoids a double redirect.
- Illegal fetch: F_PC outside the legal range, or F_PC[1:0]!=0.
  - The fetched word is replaced by 0 (nop), d_valid <= 0, and addr_err sets and stays set until reset.
  - PC sequencing continues unchanged.
  - fetch_cnt still increments; it counts accepted slots, legal or not.
- jr with a misaligned d_rs_val is taken as given; the fault is caught on the following fetch by the illegal-fetch rule.
- No internal state machine beyond the registers. Outputs d_* and addr_err are registered; im_addr is registered F_PC.

Decomposition:
- Shared package (cpu_defs): PC_RESET/IM_BASE/IM_WORDS defaults, NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11, and the NOP constant 32'h0.
- One sub-module, npc_unit (combinational target and NPC mux), instantiated inside fetch_ifid_stage. The PC and IF/ID registers stay in the top.

Test Plan:
- Reset then 3 clocks with stall=0, npc_sel=00 -> im_addr goes 0x3000, 0x3004, 0x3008, 0x300C; d_pc goes 0x3000, 0x3004, 0x3008; d_pc8=d_pc+8; fetch_cnt=3.
- beq at 0x3004 with imm16=0xFFFF and br_taken=1 -> delay slot 0x3008 enters IF/ID, next fetch is 0x3004; with br_taken=0 the next fetch is 0x300C.
- jal at 0x3010 with imm26=0x0000C10 -> next fetch 0x3040 after delay slot 0x3014; d_pc8=0x3018 while jal is in D.
- jr with d_rs_val=0x3020, stall held 2 cycles while npc_sel=11 -> PC and d_instr frozen for both cycles, fetch_cnt unchanged, single redirect to 0x3020 on release.
- jr to 0x3022, then jr to 0x7000 -> each yields a nop with d_valid=0 and addr_err=1; addr_err stays 1 until reset.
- Assert reset asynchronously mid-cycle during a taken branch -> all outputs show reset values immediately; first post-reset im_addr is 0x3000.
